hood_mode_ctrl: RTL

Main operating-mode state machine of the range hood, directly downstream of the power/gesture input stage. Consumes the debounced power_on level, plus single-cycle command pulses from the button stage. Produces fan level, display mode code, a seconds countdown for timed modes, and the cleaning-reminder flag. Everything runs on clk; second-granularity timing uses a one-cycle tick_1hz strobe.

---
 rtl/hood_mode_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hood_mode_ctrl.sv
// Range-hood operating-mode controller: power/menu/level/hurricane/self-clean
// sequencing, seconds countdown, and fan-usage tracking for the cleaning reminder.
module hood_mode_ctrl #(
    parameter int unsigned HURRICANE_S = 60,
    parameter int unsigned CLEAN_S     = 180,
    parameter int unsigned REMIND_S    = 36000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       power_on,
    input  logic       btn_menu,
    input  logic       btn_l1,
    input  logic       btn_l2,
    input  logic       btn_l3,
    input  logic       btn_clean,
    output logic [2:0] mode,
    output logic [1:0] fan_level,
    output logic [7:0] countdown,
    output logic       hurricane_used,
    output logic       clean_remind,
    output logic       clean_done
);

    // state   | meaning
    // OFF     | power off
    // STANDBY | powered, fan idle
    // MENU    | waiting for a selection
    // LVL1/2  | steady extraction level 1 / 2
    // LVL3    | timed hurricane, drops to LVL2 on expiry
    // RET     | level-3 run-down after menu, then STANDBY
    // CLEAN   | timed self-clean, fan off
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STANDBY = 3'd1,
        ST_MENU    = 3'd2,
        ST_LVL1    = 3'd3,
        ST_LVL2    = 3'd4,
        ST_LVL3    = 3'd5,
        ST_RET     = 3'd6,
        ST_CLEAN   = 3'd7
    } state_t;

    localparam logic [7:0]  HURRICANE_LD = 8'(HURRICANE_S);
    localparam logic [7:0]  CLEAN_LD     = 8'(CLEAN_S);
    localparam logic [16:0] REMIND_TH    = 17'(REMIND_S);

    state_t      state_q, state_d;
    logic [1:0]  fan_level_q, fan_level_d;
    logic [7:0]  countdown_q, countdown_d;
    logic        hurricane_used_q, hurricane_used_d;
    logic        clean_remind_q, clean_remind_d;
    logic        clean_done_q, clean_done_d;
    logic [15:0] usage_q, usage_d;
    logic        expiry;

    always_comb begin
        state_d          = state_q;
        countdown_d      = countdown_q;
        hurricane_used_d = hurricane_used_q;
        clean_done_d     = 1'b0;
        usage_d          = usage_q;
        clean_remind_d   = ({1'b0, usage_q} >= REMIND_TH);
        // countdown is only ever non-zero in the timed states
        expiry           = tick_1hz && (countdown_q == 8'd1);

        if (tick_1hz && (fan_level_q != 2'd0) && (usage_q != 16'hFFFF))
            usage_d = usage_q + 16'd1;
        if (tick_1hz && (countdown_q > 8'd1))
            countdown_d = countdown_q - 8'd1;

        if (!power_on) begin
            state_d          = ST_OFF;
            countdown_d      = 8'd0;
            hurricane_used_d = 1'b0;
        end else if (expiry) begin
            countdown_d = 8'd0;
            case (state_q)
                ST_LVL3: state_d = ST_LVL2;
                ST_CLEAN: begin
                    state_d      = ST_STANDBY;
                    clean_done_d = 1'b1;
                    usage_d      = 16'd0;
                end
                default: state_d = ST_STANDBY;
            endcase
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_STANDBY;
                ST_STANDBY: if (btn_menu) state_d = ST_MENU;
                ST_MENU: begin
                    if (btn_menu) begin
                        state_d = ST_STANDBY;
                    end else if (btn_clean) begin
                        state_d     = ST_CLEAN;
                        countdown_d = CLEAN_LD;
                    end else if (btn_l3) begin
                        if (!hurricane_used_q) begin
                            state_d          = ST_LVL3;
                            countdown_d      = HURRICANE_LD;
                            hurricane_used_d = 1'b1;
                        end
                    end else if (btn_l2) begin
                        state_d = ST_LVL2;
                    end else if (btn_l1) begin
                        state_d = ST_LVL1;
                    end
                end
                ST_LVL1, ST_LVL2: begin
                    // higher-priority ignored buttons still swallow l1/l2
                    if (btn_menu)
                        state_d = ST_STANDBY;
                    else if (!btn_clean && !btn_l3) begin
                        if (btn_l2)
                            state_d = ST_LVL2;
                        else if (btn_l1)
                            state_d = ST_LVL1;
                    end
                end
                ST_LVL3: begin
                    if (btn_menu) begin
                        state_d     = ST_RET;
                        countdown_d = HURRICANE_LD;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        case (state_d)
            ST_LVL1:         fan_level_d = 2'd1;
            ST_LVL2:         fan_level_d = 2'd2;
            ST_LVL3, ST_RET: fan_level_d = 2'd3;
            default:         fan_level_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_OFF;
            fan_level_q      <= 2'd0;
            countdown_q      <= 8'd0;
            hurricane_used_q <= 1'b0;
            clean_remind_q   <= 1'b0;
            clean_done_q     <= 1'b0;
            usage_q          <= 16'd0;
        end else begin
            state_q          <= state_d;
            fan_level_q      <= fan_level_d;
            countdown_q      <= countdown_d;
            hurricane_used_q <= hurricane_used_d;
            clean_remind_q   <= clean_remind_d;
            clean_done_q     <= clean_done_d;
            usage_q          <= usage_d;
        end
    end

    assign mode           = state_q;
    assign fan_level      = fan_level_q;
    assign countdown      = countdown_q;
    assign hurricane_used = hurricane_used_q;
    assign clean_remind   = clean_remind_q;
    assign clean_done     = clean_done_q;

endmodule
